// File: rtl/fp_correction_if.sv
// Digit-stream bundle between the field adder, the final-reduction stage and its consumer.
// The slave modport is the reduction stage's view.
interface fp_correction_if #(
    parameter int unsigned RADIX = 32
);
    logic             start;
    logic             digit_in_valid;
    logic [RADIX-1:0] digit_in;
    logic             carry_in;
    logic             out_ready;
    logic             busy;
    logic             digit_out_valid;
    logic [RADIX-1:0] digit_res;
    logic             done;
    logic             reduced;

    modport slave (
        input  start,
        input  digit_in_valid,
        input  digit_in,
        input  carry_in,
        input  out_ready,
        output busy,
        output digit_out_valid,
        output digit_res,
        output done,
        output reduced
    );

    modport master (
        output start,
        output digit_in_valid,
        output digit_in,
        output carry_in,
        output out_ready,
        input  busy,
        input  digit_out_valid,
        input  digit_res,
        input  done,
        input  reduced
    );
endinterface

// File: rtl/fp_correction.sv
// Digit-serial final reduction: buffers S and S - p, then streams S mod p (for S < 2p)
// out least-significant digit first under a valid/ready handshake.
module fp_correction #(
    parameter int unsigned             RADIX  = 32,
    parameter int unsigned             DIGITS = 14,
    parameter logic [RADIX*DIGITS-1:0] P      =
        448'h0002341F_27177344_6CFC5FD6_81C52056_7BC65C78_3158AEA3_FDC1767A_E2FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF
) (
    input logic            i_clk,
    input logic            i_rst_n,
    fp_correction_if.slave io_bus
);
    localparam int unsigned     KW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0]   LAST = KW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    logic [1:0]       r_state;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    r_j;
    logic             r_borrow;
    logic             r_sel;
    logic             r_busy;
    logic             r_valid;
    logic             r_done;
    logic [RADIX-1:0] r_res;
    logic [RADIX-1:0] r_sum  [DIGITS];
    logic [RADIX-1:0] r_diff [DIGITS];

    logic             w_start_acc;
    logic             w_in_acc;
    logic             w_out_acc;
    logic             w_sel;
    logic [RADIX-1:0] w_pk;
    logic [RADIX:0]   w_sub;
    logic [KW-1:0]    w_next_j;

    // A start coinciding with done is dropped so the next operation begins after done.
    assign w_start_acc = io_bus.start && (r_state == S_IDLE) && !r_done;
    assign w_in_acc    = io_bus.digit_in_valid && (r_state == S_COLLECT);
    assign w_out_acc   = r_valid && io_bus.out_ready && (r_state == S_EMIT);
    assign w_pk        = P[r_k*RADIX +: RADIX];
    assign w_sub       = {1'b0, io_bus.digit_in} - {1'b0, w_pk} - {{RADIX{1'b0}}, r_borrow};
    // Final carry set means S >= 2^(RADIX*DIGITS) > p; no final borrow means S >= p.
    assign w_sel       = io_bus.carry_in | ~w_sub[RADIX];
    assign w_next_j    = r_j + 1'b1;

    // Operand buffers carry no reset; every entry is rewritten before it is read.
    always_ff @(posedge i_clk) begin
        if (w_in_acc) begin
            r_sum[r_k]  <= io_bus.digit_in;
            r_diff[r_k] <= w_sub[RADIX-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_j      <= '0;
            r_borrow <= 1'b0;
            r_sel    <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_res    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_state  <= S_COLLECT;
                        r_k      <= '0;
                        r_borrow <= 1'b0;
                        r_sel    <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (w_in_acc) begin
                        r_borrow <= w_sub[RADIX];
                        if (r_k == LAST) begin
                            r_k     <= '0;
                            r_sel   <= w_sel;
                            r_state <= S_EMIT;
                            r_j     <= '0;
                            r_valid <= 1'b1;
                            r_res   <= w_sel ? r_diff[0] : r_sum[0];
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_out_acc) begin
                        if (r_j == LAST) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_res   <= '0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_j     <= '0;
                        end else begin
                            r_j   <= w_next_j;
                            r_res <= r_sel ? r_diff[w_next_j] : r_sum[w_next_j];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.busy            = r_busy;
    assign io_bus.digit_out_valid = r_valid;
    assign io_bus.digit_res       = r_res;
    assign io_bus.done            = r_done;
    assign io_bus.reduced         = r_sel;
endmodule

// File: tb/tb_fp_correction.sv
// Directed bench for fp_correction: hand-computed operands around p, stalls, ignored starts
// and a reset in the middle of the output stream.
module tb_fp_correction;
    localparam logic [447:0] P_C =
        448'h0002341F_27177344_6CFC5FD6_81C52056_7BC65C78_3158AEA3_FDC1767A_E2FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    // 2^448 - p
    localparam logic [447:0] WRAP_C =
        448'hFFFDCBE0_D8E88CBB_9303A029_7E3ADFA9_8439A387_CEA7515C_023E8985_1D000000_00000000_00000000_00000000_00000000_00000000_00000001;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    fp_correction_if #(.RADIX(32)) bus ();

    fp_correction dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [447:0] obs, input logic [447:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [447:0] s, input logic c, input bit gaps);
        int g;
        for (int i = 0; i < 14; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) tick();
            end
            bus.digit_in       = s[i*32 +: 32];
            bus.carry_in       = c;
            bus.digit_in_valid = 1'b1;
            tick();
            bus.digit_in_valid = 1'b0;
            bus.carry_in       = 1'b0;
        end
    endtask

    // Ready pattern when stalling: 1,0,0,1,0,0,...; ends in the cycle after the last handshake.
    task automatic receive(input string tag, input logic [447:0] exp, input bit stall);
        int j;
        int cyc;
        logic [31:0] e;
        j   = 0;
        cyc = 0;
        while (j < 14 && cyc < 100) begin
            bus.out_ready = (!stall || (cyc % 3 == 0));
            e = exp[j*32 +: 32];
            check($sformatf("%s valid d%0d", tag, j), 448'(bus.digit_out_valid), 448'd1);
            check($sformatf("%s digit d%0d", tag, j), 448'(bus.digit_res), 448'(e));
            if (bus.out_ready) j++;
            tick();
            cyc++;
        end
        bus.out_ready = 1'b1;
        if (j < 14) check($sformatf("%s stream timeout", tag), 448'(j), 448'd14);
        check($sformatf("%s done", tag), 448'(bus.done), 448'd1);
        check($sformatf("%s busy low", tag), 448'(bus.busy), 448'd0);
        check($sformatf("%s valid low", tag), 448'(bus.digit_out_valid), 448'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.digit_in_valid = 1'b0;
        bus.digit_in = '0;
        bus.carry_in = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst busy", 448'(bus.busy), 448'd0);
        check("rst valid", 448'(bus.digit_out_valid), 448'd0);
        check("rst res", 448'(bus.digit_res), 448'd0);
        check("rst done", 448'(bus.done), 448'd0);
        check("rst reduced", 448'(bus.reduced), 448'd0);
        rst_n = 1'b1;
        tick();

        // S = p - 1: passes through unreduced
        pulse_start();
        check("A busy", 448'(bus.busy), 448'd1);
        send(P_C - 448'd1, 1'b0, 1'b0);
        check("A latency", 448'(bus.digit_out_valid), 448'd1);
        check("A reduced", 448'(bus.reduced), 448'd0);
        receive("A", P_C - 448'd1, 1'b0);
        // start in the done cycle is dropped
        pulse_start();
        check("A start on done busy", 448'(bus.busy), 448'd0);
        check("A done pulse", 448'(bus.done), 448'd0);

        // S = p
        pulse_start();
        send(P_C, 1'b0, 1'b0);
        check("B reduced", 448'(bus.reduced), 448'd1);
        receive("B", 448'd0, 1'b0);
        tick();

        // S = p + 5
        pulse_start();
        send(P_C + 448'd5, 1'b0, 1'b0);
        check("C reduced", 448'(bus.reduced), 448'd1);
        receive("C", 448'd5, 1'b0);
        tick();

        // S = 2^448 via the final carry
        pulse_start();
        send(448'd0, 1'b1, 1'b0);
        check("D reduced", 448'(bus.reduced), 448'd1);
        receive("D", WRAP_C, 1'b0);
        tick();

        // Gapped input, stalled output, start during EMIT
        pulse_start();
        send(P_C + 448'h1234, 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        pulse_start();
        check("E start in emit busy", 448'(bus.busy), 448'd1);
        check("E reduced", 448'(bus.reduced), 448'd1);
        receive("E", 448'h1234, 1'b1);
        tick();

        // Reset while emitting digit 7
        pulse_start();
        send(P_C + 448'd5, 1'b0, 1'b0);
        repeat (7) tick();
        check("F pre-reset valid", 448'(bus.digit_out_valid), 448'd1);
        check("F pre-reset d7", 448'(bus.digit_res), 448'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("F async busy", 448'(bus.busy), 448'd0);
        check("F async valid", 448'(bus.digit_out_valid), 448'd0);
        check("F async res", 448'(bus.digit_res), 448'd0);
        check("F async done", 448'(bus.done), 448'd0);
        check("F async reduced", 448'(bus.reduced), 448'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("F idle valid", 448'(bus.digit_out_valid), 448'd0);
        check("F idle busy", 448'(bus.busy), 448'd0);

        // Fresh operation after reset: S = p + 1
        pulse_start();
        send(P_C + 448'd1, 1'b0, 1'b0);
        check("G reduced", 448'(bus.reduced), 448'd1);
        receive("G", 448'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
